// File: rtl/groovy_sched_pkg.sv
// Shared definitions for the DDR read-port scheduler: owner codes, FSM encoding
// and the burst sizing helper.
package groovy_sched_pkg;

   localparam logic [1:0] OWN_NONE  = 2'd0;
   localparam logic [1:0] OWN_SWRES = 2'd1;
   localparam logic [1:0] OWN_AUDIO = 2'd2;
   localparam logic [1:0] OWN_BLIT  = 2'd3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Smallest of the burst cap, the words left, and (for blit only) the FIFO room.
   function automatic logic [7:0] burst_min(input logic [23:0] remaining,
                                            input logic [9:0]  space,
                                            input logic        use_space,
                                            input logic [7:0]  max_burst);
      logic [23:0] m;
      m = {16'd0, max_burst};
      if (remaining < m) m = remaining;
      if (use_space && ({14'd0, space} < m)) m = {14'd0, space};
      return 8'(m);
   endfunction

endpackage

// File: rtl/groovy_sched_chan.sv
// One command channel: edge detect on the request level, pending flag, word
// pointer and remaining count, and the one-cycle done pulse.
module groovy_sched_chan (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        load,
   input  logic [23:0] count,
   input  logic        advance,
   input  logic [7:0]  burst,
   output logic        pending,
   output logic [23:0] ptr,
   output logic [23:0] remaining,
   output logic        done
);

   logic load_d;

   // A pending job with nothing left retires here, which covers both
   // zero-length jobs and jobs whose last burst just completed.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         load_d    <= 1'b0;
         pending   <= 1'b0;
         ptr       <= '0;
         remaining <= '0;
         done      <= 1'b0;
      end else begin
         load_d <= load;
         done   <= 1'b0;
         if (pending && remaining == '0) begin
            pending <= 1'b0;
            done    <= 1'b1;
         end else if (load && !load_d && !pending) begin
            pending   <= 1'b1;
            ptr       <= '0;
            remaining <= count;
         end else if (advance) begin
            ptr       <= ptr + 24'(burst);
            remaining <= remaining - 24'(burst);
         end
      end
   end

endmodule

// File: rtl/groovy_ddr_sched.sv
// Shares the DDR read port between the switchres, audio and blit channels.
//  state | meaning
//  IDLE  | arbitrate eligible channels, size the next burst
//  ISSUE | hold the Avalon read until the port accepts it
//  WAIT  | count returning beats and tag them with the owner
//  DONE  | job finished; the channel retires and pulses its reset
module groovy_ddr_sched import groovy_sched_pkg::*; #(
   parameter int            AW          = 29,
   parameter logic [AW-1:0] SWRES_BASE  = 'h0,
   parameter int            SWRES_WORDS = 4,
   parameter logic [AW-1:0] AUDIO_BASE  = 'h10000,
   parameter logic [AW-1:0] BLIT_BASE   = 'h20000,
   parameter int            MAX_BURST   = 128
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          cmd_switchres,
   input  logic          cmd_audio,
   input  logic [15:0]   audio_samples,
   input  logic          cmd_blit,
   input  logic [23:0]   blit_words,
   input  logic [9:0]    vram_space,
   input  logic          ddr_busy,
   output logic          ddr_rd,
   output logic [AW-1:0] ddr_addr,
   output logic [7:0]    ddr_burstcnt,
   input  logic          ddr_dout_ready,
   output logic [1:0]    rd_owner,
   output logic          rd_valid,
   output logic          reset_switchres,
   output logic          reset_audio,
   output logic          reset_blit,
   output logic          sched_busy
);

   localparam logic [7:0] MAX_B = 8'(MAX_BURST);

   logic [3:1]  cmd, pend, adv, done, elig;
   logic [23:0] cnt_a [1:3];
   logic [23:0] ptr_a [1:3];
   logic [23:0] rem_a [1:3];

   logic [1:0]    state, owner;
   logic [7:0]    burst, beat_left;
   logic [AW-1:0] base_sel;
   logic [23:0]   ptr_sel, rem_sel;
   logic          last_beat;

   assign cmd      = {cmd_blit, cmd_audio, cmd_switchres};
   assign cnt_a[1] = 24'(SWRES_WORDS);
   assign cnt_a[2] = 24'(({1'b0, audio_samples} + 17'd1) >> 1);
   assign cnt_a[3] = blit_words;

   for (genvar i = 1; i <= 3; i++) begin : g_chan
      groovy_sched_chan u_chan (
         .clk_sys   (clk_sys),
         .reset     (reset),
         .load      (cmd[i]),
         .count     (cnt_a[i]),
         .advance   (adv[i]),
         .burst     (burst),
         .pending   (pend[i]),
         .ptr       (ptr_a[i]),
         .remaining (rem_a[i]),
         .done      (done[i])
      );
   end

   // Zero-length jobs are never eligible; their channel retires on its own.
   assign elig[1] = pend[1] && (rem_a[1] != '0);
   assign elig[2] = pend[2] && (rem_a[2] != '0);
   assign elig[3] = pend[3] && (rem_a[3] != '0) && (vram_space != '0);

   always_comb begin
      base_sel = '0;
      ptr_sel  = '0;
      rem_sel  = '0;
      case (owner)
         OWN_SWRES: begin base_sel = SWRES_BASE; ptr_sel = ptr_a[1]; rem_sel = rem_a[1]; end
         OWN_AUDIO: begin base_sel = AUDIO_BASE; ptr_sel = ptr_a[2]; rem_sel = rem_a[2]; end
         OWN_BLIT:  begin base_sel = BLIT_BASE;  ptr_sel = ptr_a[3]; rem_sel = rem_a[3]; end
         default:   ;
      endcase
   end

   assign last_beat = (state == ST_WAIT) && ddr_dout_ready && (beat_left == 8'd1);
   assign adv       = {owner == OWN_BLIT, owner == OWN_AUDIO, owner == OWN_SWRES} & {3{last_beat}};

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         owner     <= OWN_NONE;
         burst     <= '0;
         beat_left <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (elig[1]) begin
                  owner <= OWN_SWRES;
                  burst <= burst_min(rem_a[1], vram_space, 1'b0, MAX_B);
                  state <= ST_ISSUE;
               end else if (elig[2]) begin
                  owner <= OWN_AUDIO;
                  burst <= burst_min(rem_a[2], vram_space, 1'b0, MAX_B);
                  state <= ST_ISSUE;
               end else if (elig[3]) begin
                  owner <= OWN_BLIT;
                  burst <= burst_min(rem_a[3], vram_space, 1'b1, MAX_B);
                  state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (!ddr_busy) begin
                  beat_left <= burst;
                  state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (ddr_dout_ready) begin
                  beat_left <= beat_left - 8'd1;
                  if (beat_left == 8'd1)
                     state <= (rem_sel == {16'd0, burst}) ? ST_DONE : ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
               owner <= OWN_NONE;
            end
         endcase
      end
   end

   assign ddr_rd          = (state == ST_ISSUE);
   assign ddr_addr        = ddr_rd ? (base_sel + AW'(ptr_sel)) : '0;
   assign ddr_burstcnt    = ddr_rd ? burst : '0;
   assign rd_valid        = (state == ST_WAIT) && ddr_dout_ready;
   assign rd_owner        = rd_valid ? owner : OWN_NONE;
   assign reset_switchres = done[1];
   assign reset_audio     = done[2];
   assign reset_blit      = done[3];
   assign sched_busy      = (|pend) || (state != ST_IDLE);

endmodule
